// File: rtl/ps2_mouse_host_ctrl_pkg.sv
// Shared states, PS/2 command/response codes and helpers for the mouse host sequencer.
package ps2_mouse_pkg;

  typedef enum logic [3:0] {
    S_SEND_RST     = 4'd0,
    S_WAIT_RST_TX  = 4'd1,
    S_WAIT_RST_ACK = 4'd2,
    S_WAIT_BAT     = 4'd3,
    S_WAIT_ID      = 4'd4,
    S_SEND_EN      = 4'd5,
    S_WAIT_EN_TX   = 4'd6,
    S_WAIT_EN_ACK  = 4'd7,
    S_STREAM       = 4'd8,
    S_FAIL         = 4'd9
  } state_t;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  // States in which the response timeout counter runs
  function automatic logic is_wait(input state_t s);
    return (s == S_WAIT_RST_TX) || (s == S_WAIT_RST_ACK) || (s == S_WAIT_BAT) ||
           (s == S_WAIT_ID) || (s == S_WAIT_EN_TX) || (s == S_WAIT_EN_ACK);
  endfunction

endpackage

// File: rtl/ps2_mouse_host_ctrl_if.sv
// Bundle between the mouse host sequencer, the PS/2 byte controller and cursor logic.
interface ps2_mouse_host_ctrl_if;
  import ps2_mouse_pkg::*;

  logic [7:0] cmd_data;
  logic       cmd_send;
  logic       cmd_sent;
  logic       cmd_tx_timeout;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       pkt_valid;
  logic [7:0] pkt_status;
  logic [8:0] pkt_dx;
  logic [8:0] pkt_dy;
  logic       ready;
  logic       init_fail;

  modport master (
    output cmd_data, cmd_send, pkt_valid, pkt_status, pkt_dx, pkt_dy, ready, init_fail,
    input  cmd_sent, cmd_tx_timeout, rx_data, rx_valid
  );

  modport slave (
    input  cmd_data, cmd_send, pkt_valid, pkt_status, pkt_dx, pkt_dy, ready, init_fail,
    output cmd_sent, cmd_tx_timeout, rx_data, rx_valid
  );
endinterface

// File: rtl/ps2_mouse_host_ctrl_pkt_assembler.sv
// Frames streamed mouse bytes into aligned 3-byte packets.
// Optional intra-packet gap timeout enabled by defining PS2_PKT_GAP_EN.
module ps2_pkt_assembler
  import ps2_mouse_pkg::*;
#(
  parameter int PKT_GAP_CYC = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       pkt_valid,
  output logic [7:0] pkt_status,
  output logic [8:0] pkt_dx,
  output logic [8:0] pkt_dy
);

  logic [1:0] idx;
  logic [7:0] b0, b1;
  logic       gap_hit;

`ifdef PS2_PKT_GAP_EN
  localparam int GW = $clog2(PKT_GAP_CYC + 1);
  logic [GW-1:0] gap;

  assign gap_hit = (gap == GW'(PKT_GAP_CYC));

  always_ff @(posedge clk) begin
    if (reset || !en || rx_valid || idx == 2'd0 || gap_hit) gap <= '0;
    else                                                    gap <= gap + GW'(1);
  end
`else
  localparam int unused_gap = PKT_GAP_CYC;
  assign gap_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= 2'd0;
      b0         <= '0;
      b1         <= '0;
      pkt_valid  <= 1'b0;
      pkt_status <= '0;
      pkt_dx     <= '0;
      pkt_dy     <= '0;
    end else begin
      pkt_valid <= 1'b0;
      if (!en) begin
        idx <= 2'd0;
      end else if (rx_valid) begin
        case (idx)
          2'd0: begin
            // Byte 0 always carries bit3=1; anything else is a misaligned byte
            if (rx_data[3]) begin
              b0  <= rx_data;
              idx <= 2'd1;
            end
          end
          2'd1: begin
            b1  <= rx_data;
            idx <= 2'd2;
          end
          default: begin
            pkt_status <= b0;
            pkt_dx     <= {b0[4], b1};
            pkt_dy     <= {b0[5], rx_data};
            pkt_valid  <= 1'b1;
            idx        <= 2'd0;
          end
        endcase
      end else if (gap_hit) begin
        idx <= 2'd0;
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_host_ctrl.sv
// PS/2 mouse init sequencer (reset, BAT, ID, enable) with retries, then packet streaming.
// Packet gap timeout in the assembler is enabled by defining PS2_PKT_GAP_EN.
module ps2_mouse_host_ctrl
  import ps2_mouse_pkg::*;
#(
  parameter int RESP_TIMEOUT_CYC = 1_000_000,
  parameter int BAT_TIMEOUT_CYC  = 25_000_000,
  parameter int MAX_RETRIES      = 3,
  parameter int PKT_GAP_CYC      = 100_000
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  ps2_mouse_host_ctrl_if.master bus
);

  localparam int TMAX = (BAT_TIMEOUT_CYC > RESP_TIMEOUT_CYC) ? BAT_TIMEOUT_CYC : RESP_TIMEOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int AW   = $clog2(MAX_RETRIES + 1);
  localparam logic [TW-1:0] RESP_LIM = TW'(RESP_TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] BAT_LIM  = TW'(BAT_TIMEOUT_CYC - 1);

  state_t        state, nxt;
  logic [TW-1:0] tmr;
  logic [AW-1:0] attempts, att_inc;
  logic          fail, tmo;

  assign att_inc = attempts + AW'(1);
  assign tmo     = (state == S_WAIT_BAT) ? (tmr == BAT_LIM) : (tmr == RESP_LIM);

  // Event priority inside a WAIT state: rx/cmd_sent, then tx timeout, then overflow
  always_comb begin
    nxt  = state;
    fail = 1'b0;
    case (state)
      S_SEND_RST: nxt = S_WAIT_RST_TX;
      S_SEND_EN:  nxt = S_WAIT_EN_TX;
      S_WAIT_RST_TX, S_WAIT_EN_TX: begin
        if (bus.cmd_sent)                  nxt  = (state == S_WAIT_RST_TX) ? S_WAIT_RST_ACK : S_WAIT_EN_ACK;
        else if (bus.cmd_tx_timeout || tmo) fail = 1'b1;
      end
      S_WAIT_RST_ACK, S_WAIT_EN_ACK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == RSP_ACK)         nxt = (state == S_WAIT_RST_ACK) ? S_WAIT_BAT : S_STREAM;
          else if (bus.rx_data == RSP_RESEND) nxt = (state == S_WAIT_RST_ACK) ? S_SEND_RST : S_SEND_EN;
          else                                fail = 1'b1;
        end else if (tmo) begin
          fail = 1'b1;
        end
      end
      S_WAIT_BAT: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == RSP_BAT_OK) nxt = S_WAIT_ID;
          else                           fail = 1'b1;
        end else if (tmo) begin
          fail = 1'b1;
        end
      end
      S_WAIT_ID: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == RSP_ID) nxt = S_SEND_EN;
          else                       fail = 1'b1;
        end else if (tmo) begin
          fail = 1'b1;
        end
      end
      default: nxt = state;
    endcase
    if (fail) nxt = (att_inc == AW'(MAX_RETRIES)) ? S_FAIL : S_SEND_RST;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= S_SEND_RST;
      tmr           <= '0;
      attempts      <= '0;
      bus.cmd_data  <= 8'h00;
      bus.cmd_send  <= 1'b0;
      bus.ready     <= 1'b0;
      bus.init_fail <= 1'b0;
    end else begin
      state         <= nxt;
      bus.cmd_send  <= 1'b0;
      bus.ready     <= (nxt == S_STREAM);
      bus.init_fail <= (nxt == S_FAIL);
      if (fail) attempts <= att_inc;
      if (nxt != state || !is_wait(state)) tmr <= '0;
      else                                  tmr <= tmr + TW'(1);
      if (state == S_SEND_RST) begin
        bus.cmd_data <= CMD_RESET;
        bus.cmd_send <= 1'b1;
      end else if (state == S_SEND_EN) begin
        bus.cmd_data <= CMD_ENABLE;
        bus.cmd_send <= 1'b1;
      end
    end
  end

  ps2_pkt_assembler #(.PKT_GAP_CYC(PKT_GAP_CYC)) u_asm (
    .clk        (CLOCK_50),
    .reset      (reset),
    .en         (state == S_STREAM),
    .rx_data    (bus.rx_data),
    .rx_valid   (bus.rx_valid),
    .pkt_valid  (bus.pkt_valid),
    .pkt_status (bus.pkt_status),
    .pkt_dx     (bus.pkt_dx),
    .pkt_dy     (bus.pkt_dy)
  );

endmodule

// File: tb/tb_ps2_mouse_host_ctrl.sv
// Scoreboard bench: stimulus queues expected commands/packets, a monitor checks them.
module tb_ps2_mouse_host_ctrl;
  import ps2_mouse_pkg::*;

  localparam int RESP = 50;
  localparam int BAT  = 100;
  localparam int GAP  = 20;

  typedef struct {
    logic [7:0] st;
    logic [8:0] dx;
    logic [8:0] dy;
  } pkt_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_mouse_host_ctrl_if bus();

  ps2_mouse_host_ctrl #(
    .RESP_TIMEOUT_CYC (RESP),
    .BAT_TIMEOUT_CYC  (BAT),
    .MAX_RETRIES      (3),
    .PKT_GAP_CYC      (GAP)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  int total = 0;
  int bad = 0;
  int n_cmd = 0;
  logic [7:0] cq[$];
  pkt_t       pq[$];
  logic [7:0] exp_cmd;
  pkt_t       exp_pkt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cmd_send) begin
        n_cmd++;
        if (cq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cmd_unexpected: got cmd %0h want none", bus.cmd_data);
        end else begin
          exp_cmd = cq.pop_front();
          chk("cmd_data", {24'b0, bus.cmd_data}, {24'b0, exp_cmd});
        end
      end
      if (bus.pkt_valid) begin
        if (pq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pkt_unexpected: got %0h/%0h/%0h want none", bus.pkt_status, bus.pkt_dx, bus.pkt_dy);
        end else begin
          exp_pkt = pq.pop_front();
          chk("pkt_status", {24'b0, bus.pkt_status}, {24'b0, exp_pkt.st});
          chk("pkt_dx", {23'b0, bus.pkt_dx}, {23'b0, exp_pkt.dx});
          chk("pkt_dy", {23'b0, bus.pkt_dy}, {23'b0, exp_pkt.dy});
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_sent();
    bus.cmd_sent = 1'b1;
    tick(1);
    bus.cmd_sent = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_cmd(input string name);
    int i;
    for (i = 0; i < 300 && !bus.cmd_send; i++) tick(1);
    if (!bus.cmd_send) begin
      total++;
      bad++;
      $display("FAIL %s: got no cmd_send within 300 cycles want cmd_send", name);
    end
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.cmd_sent       = 1'b0;
    bus.cmd_tx_timeout = 1'b0;
    bus.rx_valid       = 1'b0;
    bus.rx_data        = 8'h00;
    tick(3);
    n_cmd = 0;
  endtask

  task automatic push_pkt(input logic [7:0] st, input logic [8:0] dx, input logic [8:0] dy);
    pkt_t p;
    p.st = st;
    p.dx = dx;
    p.dy = dy;
    pq.push_back(p);
  endtask

  task automatic do_init();
    cq.push_back(8'hFF);
    cq.push_back(8'hF4);
    reset = 1'b0;
    tick(1);
    chk("cmd_send_after_reset", {31'b0, bus.cmd_send}, 32'd1);
    pulse_sent();
    rx(8'hFA);
    rx(8'hAA);
    rx(8'h00);
    wait_cmd("en_cmd");
    pulse_sent();
    chk("ready_before_ack", {31'b0, bus.ready}, 32'd0);
    rx(8'hFA);
    chk("ready_after_ack", {31'b0, bus.ready}, 32'd1);
  endtask

  initial begin
    bus.cmd_sent       = 1'b0;
    bus.cmd_tx_timeout = 1'b0;
    bus.rx_valid       = 1'b0;
    bus.rx_data        = 8'h00;

    // Reset state
    do_reset();
    chk("rst_cmd_send",   {31'b0, bus.cmd_send},   32'd0);
    chk("rst_cmd_data",   {24'b0, bus.cmd_data},   32'd0);
    chk("rst_ready",      {31'b0, bus.ready},      32'd0);
    chk("rst_init_fail",  {31'b0, bus.init_fail},  32'd0);
    chk("rst_pkt_valid",  {31'b0, bus.pkt_valid},  32'd0);
    chk("rst_pkt_status", {24'b0, bus.pkt_status}, 32'd0);

    // Nominal init
    do_init();
    tick(2);
    chk("nominal_cmd_count", n_cmd, 32'd2);
    chk("nominal_attempts", {28'b0, 4'(dut.attempts)}, 32'd0);

    // Packet framing, sign extension, overflow pass-through, resync
    push_pkt(8'h08, 9'h005, 9'h003);
    rx(8'h08); rx(8'h05); rx(8'h03); tick(2);
    push_pkt(8'h18, 9'h1FB, 9'h000);
    rx(8'h18); rx(8'hFB); rx(8'h00); tick(2);
    push_pkt(8'hC8, 9'h010, 9'h020);
    rx(8'hC8); rx(8'h10); rx(8'h20); tick(2);
    push_pkt(8'h28, 9'h001, 9'h1FF);
    rx(8'h28); rx(8'h01); rx(8'hFF); tick(2);
    push_pkt(8'h08, 9'h002, 9'h001);
    rx(8'h05); rx(8'h08); rx(8'h02); rx(8'h01); tick(2);

    // Long gap after byte 0
`ifdef PS2_PKT_GAP_EN
    push_pkt(8'h09, 9'h001, 9'h002);
`else
    push_pkt(8'h08, 9'h009, 9'h001);
`endif
    rx(8'h08); tick(25);
    rx(8'h09); rx(8'h01); rx(8'h02); tick(3);
    chk("pkt_queue_drained", pq.size(), 32'd0);

    // Reset mid-packet clears everything and restarts init
    rx(8'h08); rx(8'h05);
    do_reset();
    chk("midrst_ready",      {31'b0, bus.ready},      32'd0);
    chk("midrst_pkt_status", {24'b0, bus.pkt_status}, 32'd0);
    chk("midrst_pkt_dx",     {23'b0, bus.pkt_dx},     32'd0);
    chk("midrst_pkt_dy",     {23'b0, bus.pkt_dy},     32'd0);
    do_init();
    push_pkt(8'h0A, 9'h007, 9'h006);
    rx(8'h0A); rx(8'h07); rx(8'h06); tick(2);

    // Resend response re-issues FF without consuming an attempt
    do_reset();
    cq.push_back(8'hFF);
    cq.push_back(8'hFF);
    cq.push_back(8'hF4);
    reset = 1'b0;
    wait_cmd("resend_first");
    pulse_sent();
    rx(8'hFE);
    wait_cmd("resend_again");
    chk("resend_attempts", {28'b0, 4'(dut.attempts)}, 32'd0);
    pulse_sent();
    rx(8'hFA); rx(8'hAA); rx(8'h00);
    wait_cmd("resend_en");
    pulse_sent();
    rx(8'hFA);
    chk("resend_ready", {31'b0, bus.ready}, 32'd1);
    tick(2);
    chk("resend_cmd_count", n_cmd, 32'd3);

    // No ACK ever: three timeouts end in FAIL
    do_reset();
    for (int k = 0; k < 3; k++) cq.push_back(8'hFF);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_cmd("retry_cmd");
      pulse_sent();
    end
    tick(150);
    chk("fail_init_fail", {31'b0, bus.init_fail}, 32'd1);
    chk("fail_ready",     {31'b0, bus.ready},     32'd0);
    chk("fail_state",     {28'b0, 4'(dut.state)}, {28'b0, 4'(S_FAIL)});
    chk("fail_cmd_count", n_cmd, 32'd3);

    chk("cmd_queue_empty", cq.size(), 32'd0);
    chk("pkt_queue_empty", pq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_host_ctrl.md
# ps2_mouse_host_ctrl

Host-side sequencer for the PS/2 mouse path, sitting between the PS/2 byte-level controller and the cursor-tracking logic. After reset it initializes the mouse: reset command, self-test, device ID, then enable data reporting. It retries on failure, then frames the streamed bytes into aligned 3-byte movement packets. Cursor logic consumes only `pkt_valid` packets, so it never sees init responses or misaligned bytes.

## Interface
Parameters:
- RESP_TIMEOUT_CYC, 1_000_000 — max cycles waiting for ACK/ID (20 ms at 50 MHz)
- BAT_TIMEOUT_CYC, 25_000_000 — max cycles waiting for self-test byte (500 ms)
- MAX_RETRIES, 3 — full init attempts before declaring failure
- PKT_GAP_CYC, 100_000 — max intra-packet byte gap (used only with the macro)

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_data  out  8  command byte to the PS/2 controller
- cmd_send  out  1  one-cycle send strobe
- cmd_sent  in  1  controller finished transmitting
- cmd_tx_timeout  in  1  controller transmit timeout
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- pkt_valid  out  1  one-cycle strobe, packet outputs valid
- pkt_status  out  8  byte 0 (buttons, sign, overflow)
- pkt_dx  out  9  signed X delta {status[4], byte1}
- pkt_dy  out  9  signed Y delta {status[5], byte2}
- ready  out  1  init complete, streaming
- init_fail  out  1  retries exhausted

## Operation
- States: SEND_RST → WAIT_RST_TX → WAIT_RST_ACK → WAIT_BAT → WAIT_ID → SEND_EN → WAIT_EN_TX → WAIT_EN_ACK → STREAM; terminal FAIL.
- SEND_RST
  - drive cmd_data=8'hFF and pulse cmd_send, then go to WAIT_RST_TX.
  - SEND_EN does the same with 8'hF4.
- WAIT_*_TX: cmd_sent advances to the matching WAIT_*_ACK; cmd_tx_timeout is a failure.
- WAIT_RST_ACK / WAIT_EN_ACK:
  - 8'hFA advances.
  - 8'hFE (resend) returns to the same SEND state; this does not count as a retry.
  - any other byte is a failure.
- WAIT_BAT: 8'hAA advances; any other byte is a failure.
- WAIT_ID: 8'h00 advances; any other byte is a failure.
- Timeout counter
  - clears on every state entry; overflow at the state's limit is a failure.
  - WAIT_BAT uses BAT_TIMEOUT_CYC; the other WAIT states use RESP_TIMEOUT_CYC.
- Failure handling
  - increment the attempt counter.
  - attempt counter == MAX_RETRIES → FAIL.
  - otherwise → SEND_RST.
- FAIL: init_fail=1 and stays there until reset.
- STREAM: ready=1; byte index 0..2.
  - index 0: a byte with bit3=0 is discarded (resync) and the index stays 0.
  - on the third byte, register pkt_status/pkt_dx/pkt_dy and pulse pkt_valid.
- Overflow bits [7:6] pass through in pkt_status; the deltas are not saturated.
- rx_valid in SEND/WAIT_TX states is ignored.

## Timing
- Reset values:
  - state SEND_RST; all counters 0.
  - cmd_send, pkt_valid, ready, init_fail = 0.
  - cmd_data = 8'h00; pkt_status/pkt_dx/pkt_dy = 0.
- First cmd_send: the cycle after reset deasserts.
- cmd_send is high exactly one cycle per SEND state entry; cmd_data is held stable until the next SEND.
- ready rises the cycle after 8'hFA is accepted in WAIT_EN_ACK.
- pkt_valid is high the cycle after rx_valid of byte 2; outputs hold until the next packet.
- Simultaneous events in a WAIT state:
  - rx_valid wins over the timeout overflow in the same cycle.
  - cmd_sent wins over cmd_tx_timeout.
- reset mid-packet or mid-init: everything returns to reset values in the next cycle, and init restarts.

## Configuration
- PS2_PKT_GAP_EN defined
  - in STREAM, a gap counter runs while index ≠ 0.
  - exceeding PKT_GAP_CYC without rx_valid resets the index to 0 and drops the partial packet.
- PS2_PKT_GAP_EN undefined: no gap counter; realignment relies only on the bit3 check.

## Structure
- Package ps2_mouse_pkg holds:
  - the state enum.
  - command constants CMD_RESET=8'hFF, CMD_ENABLE=8'hF4.
  - response constants RSP_ACK=8'hFA, RSP_RESEND=8'hFE, RSP_BAT_OK=8'hAA, RSP_ID=8'h00.
- Sub-module ps2_pkt_assembler owns the STREAM byte index, the bit3 check, the optional gap counter and the packet registers. It is enabled by the top FSM when in STREAM.

## Test plan
Run with small timeouts (RESP 50, BAT 100, GAP 20).
- Nominal init: answer FF with sent, FA, AA, 00; answer F4 with sent, FA → exactly two cmd_send pulses (FF, F4), then ready=1.
- Resend: after FF is sent, respond FE → FF re-sent; attempt counter unchanged; completing the sequence gives ready=1.
- Exhausted retries: never respond after cmd_sent → after 3 timeouts init_fail=1, state FAIL, no further cmd_send.
- Packet framing in STREAM: bytes 08, 05, 03 → pkt_valid once; pkt_dx=9'h005, pkt_dy=9'h003. Bytes 18, FB, 00 → pkt_dx=9'h1FB (−5).
- Resync: stream 05, 08, 02, 01 → the 05 is dropped; one packet with status 08, dx=2, dy=1.
- With PS2_PKT_GAP_EN: send 08, wait 25 cycles, then 09, 01, 02 → packet status 09, dx=1, dy=2. Without the macro, the same stimulus gives status 08, dx=9, dy=1.
